// File: rtl/top_level.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : top_level                                                   |
// | Function : Hamming SECDED decoder sweeping 15 codewords held in an     |
// |            internal byte memory (dm1). Source codeword i sits at bytes |
// |            30+2i (low) and 31+2i (high). The decoded result            |
// |            {F1,F0,000,d11..d1} goes to bytes 2i (low) and 2i+1 (high). |
// | Config   : define TOP_LEVEL_DED_EN to enable double-error detection.   |
// |            Without it, the overall parity bit takes no part in         |
// |            classification and F1 is always 0.                          |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+

module top_level_dmem (
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] core [0:255];

  // Synchronous single-byte write. Contents are never cleared by reset.
  always_ff @(posedge clk) begin
    if (we) core[addr] <= wdata;
  end

  assign rdata = core[addr];

endmodule

module top_level (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_LO  = 3'd1,
    RD_HI  = 3'd2,
    DECODE = 3'd3,
    WR_LO  = 3'd4,
    WR_HI  = 3'd5,
    FIN    = 3'd6
  } state_t;

  localparam logic [3:0] LAST_WORD = 4'd14;

  state_t      state, state_nx;
  logic [3:0]  idx, idx_nx;
  logic        start_q;
  logic [7:0]  lo_byte, hi_byte;
  logic [15:0] result, decoded;
  logic [7:0]  base;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  top_level_dmem dm1 (
    .clk   (clk),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  // Byte offset of the current word: 2*i.
  assign base = {3'b000, idx, 1'b0};
  assign done = (state == FIN);

  // Control state, word index and start-edge tracker.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= 4'd0;
      start_q <= 1'b0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      start_q <= start;
    end
  end

  // Datapath capture: the two codeword bytes, then the decoded result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lo_byte <= 8'h00;
      hi_byte <= 8'h00;
      result  <= 16'h0000;
    end else begin
      if (state == RD_LO)  lo_byte <= mem_rdata;
      if (state == RD_HI)  hi_byte <= mem_rdata;
      if (state == DECODE) result  <= decoded;
    end
  end

  // SECDED decode of the captured codeword into {flags, 000, data}.
  always_comb begin
    logic [15:0] cw;
    logic [15:0] corr;
    logic [3:0]  syn;
    logic        par;
    logic [1:0]  flags;
    cw    = {hi_byte, lo_byte};
    syn   = 4'd0;
    for (int j = 1; j < 16; j++) begin
      if (cw[j]) syn = syn ^ j[3:0];
    end
    par   = ^cw;
    corr  = cw;
    flags = 2'b00;
`ifdef TOP_LEVEL_DED_EN
    if (par) begin
      // Single error; S=0 points at p0, which carries no data.
      corr  = cw ^ (16'h0001 << syn);
      flags = 2'b01;
    end else if (syn != 4'd0) begin
      // Double error: data is passed through uncorrected.
      flags = 2'b10;
    end
`else
    if (syn != 4'd0) begin
      corr  = cw ^ (16'h0001 << syn);
      flags = 2'b01;
    end
`endif
    decoded = {flags, 3'b000, corr[15:9], corr[7:5], corr[3]};
  end

  // Next-state, memory address and write strobe. A high start always wins.
  always_comb begin
    state_nx  = state;
    idx_nx    = idx;
    mem_addr  = base + 8'd30;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    case (state)
      IDLE: begin
        if (start_q) begin
          state_nx = RD_LO;
          idx_nx   = 4'd0;
        end
      end
      RD_LO: begin
        mem_addr = base + 8'd30;
        state_nx = RD_HI;
      end
      RD_HI: begin
        mem_addr = base + 8'd31;
        state_nx = DECODE;
      end
      DECODE: begin
        state_nx = WR_LO;
      end
      WR_LO: begin
        mem_addr  = base;
        mem_we    = 1'b1;
        mem_wdata = result[7:0];
        state_nx  = WR_HI;
      end
      WR_HI: begin
        mem_addr  = base | 8'd1;
        mem_we    = 1'b1;
        mem_wdata = result[15:8];
        if (idx < LAST_WORD) begin
          state_nx = RD_LO;
          idx_nx   = idx + 4'd1;
        end else begin
          state_nx = FIN;
        end
      end
      FIN: begin
        state_nx = FIN;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    if (start) begin
      state_nx = IDLE;
      idx_nx   = 4'd0;
      mem_we   = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_top_level.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_top_level                                                |
// | Function : Self-checking bench for top_level: randomized SECDED words   |
// |            against a behavioural decode model, plus directed control   |
// |            scenarios (abort, reset mid-run, rerun).                    |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+

module tb_top_level;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic done;

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_en = 1'b0;

  logic [15:0] src [0:14];

  always #5 clk = ~clk;

  top_level dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .done  (done)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
    end
  endtask

  // Syndrome: XOR of the indices of all set bits 1..15.
  function automatic logic [3:0] syndrome(input logic [15:0] w);
    logic [3:0] s;
    s = 4'd0;
    for (int k = 1; k < 16; k++) if (w[k]) s = s ^ 4'(k);
    return s;
  endfunction

  // Reference decode from the classification rules.
  function automatic logic [15:0] ref_decode(input logic [15:0] w);
    logic [15:0] c;
    logic [1:0]  f;
    logic [10:0] d;
    logic [3:0]  s;
    logic        p;
    s = syndrome(w);
    p = ^w;
    c = w;
    f = 2'b00;
`ifdef TOP_LEVEL_DED_EN
    if (p) begin
      c[s] = ~c[s];
      f    = 2'b01;
    end else if (s != 4'd0) begin
      f = 2'b10;
    end
`else
    if (s != 4'd0) begin
      c[s] = ~c[s];
      f    = 2'b01;
    end
`endif
    d[0]    = c[3];
    d[3:1]  = c[7:5];
    d[10:4] = c[15:9];
    return {f, 3'b000, d};
  endfunction

  // Build a valid codeword around 11 data bits.
  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] c;
    logic [3:0]  s;
    c       = 16'h0000;
    c[3]    = d[0];
    c[7:5]  = d[3:1];
    c[15:9] = d[10:4];
    s       = syndrome(c);
    c[1]    = s[0];
    c[2]    = s[1];
    c[4]    = s[2];
    c[8]    = s[3];
    c[0]    = ^c[15:1];
    return c;
  endfunction

  // Flip n (0..2) distinct random bits.
  function automatic logic [15:0] corrupt(input logic [15:0] w, input int n);
    int a, b;
    a = int'($urandom_range(15, 0));
    b = (a + int'($urandom_range(15, 1))) % 16;
    if (n >= 1) w[a] = ~w[a];
    if (n >= 2) w[b] = ~w[b];
    return w;
  endfunction

  // Behavioural expectation for done: a run launches on a start fall and
  // finishes 75 clocks later (15 words x 5 clocks); start high aborts.
  logic m_prev, m_run;
  int   m_cnt;
  logic exp_done;

  // Control-level model of the run timeline.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_prev <= 1'b0;
      m_run  <= 1'b0;
      m_cnt  <= 0;
    end else begin
      m_prev <= start;
      if (start) begin
        m_run <= 1'b0;
        m_cnt <= 0;
      end else if (m_prev) begin
        m_run <= 1'b1;
        m_cnt <= 0;
      end else if (m_run && m_cnt < 75) begin
        m_cnt <= m_cnt + 1;
      end
    end
  end

  assign exp_done = m_run && (m_cnt >= 75);

  // Per-cycle check of done against the model.
  always @(negedge clk) begin
    if (chk_en) chk("done_per_cycle", {15'h0, done}, {15'h0, exp_done});
  end

  task automatic randomize_src();
    for (int s = 0; s < 15; s++)
      src[s] = corrupt(encode(11'($urandom)), int'($urandom_range(2, 0)));
  endtask

  task automatic load_src();
    for (int s = 0; s < 15; s++) begin
      dut.dm1.core[30 + 2*s] = src[s][7:0];
      dut.dm1.core[31 + 2*s] = src[s][15:8];
    end
  endtask

  task automatic launch();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_latency_le_80"}, {15'h0, (done === 1'b1) && (cyc <= 80)}, 16'h0001);
  endtask

  task automatic check_slots(input string tag, input int first, input int last);
    for (int s = first; s <= last; s++)
      chk($sformatf("%s_slot%0d", tag, s),
          {dut.dm1.core[2*s + 1], dut.dm1.core[2*s]}, ref_decode(src[s]));
  endtask

  task automatic check_sources(input string tag);
    for (int s = 0; s < 15; s++) begin
      chk($sformatf("%s_src_lo%0d", tag, s), {8'h00, dut.dm1.core[30 + 2*s]}, {8'h00, src[s][7:0]});
      chk($sformatf("%s_src_hi%0d", tag, s), {8'h00, dut.dm1.core[31 + 2*s]}, {8'h00, src[s][15:8]});
    end
  endtask

  initial begin
    logic [15:0] prev14;

    // Pin the reference model with hand-computed values.
    chk("model_FFFF", ref_decode(16'hFFFF), 16'h07FF);
    chk("model_0008", ref_decode(16'h0008), 16'h4000);
    chk("model_7FFF", ref_decode(16'h7FFF), 16'h47FF);
    chk("model_enc7FF", encode(11'h7FF), 16'hFFFF);
`ifdef TOP_LEVEL_DED_EN
    chk("model_0001", ref_decode(16'h0001), 16'h4000);
    chk("model_0028", ref_decode(16'h0028), 16'h8003);
`else
    chk("model_0001", ref_decode(16'h0001), 16'h0000);
    chk("model_0028", ref_decode(16'h0028), 16'h4007);
`endif

    for (int k = 0; k < 256; k++) dut.dm1.core[k] = 8'($urandom);

    repeat (3) @(negedge clk);
    chk("reset_done", {15'h0, done}, 16'h0000);
    #2 reset = 1'b1;
    chk_en = 1'b1;

    // Directed run: known codewords in the first five slots.
    randomize_src();
    src[0] = 16'hFFFF;
    src[1] = 16'h0008;
    src[2] = 16'h7FFF;
    src[3] = 16'h0001;
    src[4] = 16'h0028;
    @(negedge clk);
    load_src();
    launch();
    wait_done("directed");
    check_slots("directed", 0, 14);
    check_sources("directed");
    chk("no_err_hi", {8'h00, dut.dm1.core[1]}, 16'h0007);
    chk("no_err_lo", {8'h00, dut.dm1.core[0]}, 16'h00FF);
    chk("single_0008", {dut.dm1.core[3], dut.dm1.core[2]}, 16'h4000);
    chk("single_7FFF", {dut.dm1.core[5], dut.dm1.core[4]}, 16'h47FF);
`ifdef TOP_LEVEL_DED_EN
    chk("p0_only_0001", {dut.dm1.core[7], dut.dm1.core[6]}, 16'h4000);
    chk("double_0028", {dut.dm1.core[9], dut.dm1.core[8]}, 16'h8003);
    chk("double_flag_bit", {15'h0, dut.dm1.core[9][7]}, 16'h0001);
`else
    chk("p0_only_0001", {dut.dm1.core[7], dut.dm1.core[6]}, 16'h0000);
    chk("sec_only_0028", {dut.dm1.core[9], dut.dm1.core[8]}, 16'h4007);
`endif
    repeat (5) @(negedge clk);

    // Randomized runs.
    for (int r = 0; r < 4; r++) begin
      randomize_src();
      load_src();
      launch();
      wait_done($sformatf("rand%0d", r));
      check_slots($sformatf("rand%0d", r), 0, 14);
      check_sources($sformatf("rand%0d", r));
      repeat (2) @(negedge clk);
    end

    // Abort by raising start mid-run; the following fall reruns.
    randomize_src();
    load_src();
    launch();
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk("abort_done_low", {15'h0, done}, 16'h0000);
    repeat (3) @(negedge clk);
    chk("abort_idle_done_low", {15'h0, done}, 16'h0000);
    start = 1'b0;
    wait_done("rerun_after_abort");
    check_slots("rerun_after_abort", 0, 14);
    check_sources("rerun_after_abort");
    prev14 = ref_decode(src[14]);

    // Reset mid-run: earlier slots keep their results, the rest is untouched.
    randomize_src();
    load_src();
    launch();
    repeat (40) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("reset_mid_done_low", {15'h0, done}, 16'h0000);
    check_slots("reset_mid", 0, 5);
    check_sources("reset_mid");
    chk("reset_mid_slot14_retained", {dut.dm1.core[29], dut.dm1.core[28]}, prev14);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    launch();
    wait_done("rerun_after_reset");
    check_slots("rerun_after_reset", 0, 14);
    check_sources("rerun_after_reset");

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
